sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive mismatch cycles needed to flip a debounced input; legal range 2..255.
REQ-002 Parameter DELAY_CYCLES, default 8, is the entry-delay length in cycles from trigger rise to confirm; legal range 2..255.
REQ-003 Port clk, input, 1 bit: the single clock, rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port arm_raw, input, 1 bit: raw arm keyswitch, asynchronous to clk.
REQ-006 Port door_raw, input, 1 bit: raw door contact, asynchronous to clk.
REQ-007 Port motion_raw, input, 1 bit: raw motion sensor, asynchronous to clk.
REQ-008 Port clr_count, input, 1 bit: synchronous clear of trig_count.
REQ-009 Port arm, output, 1 bit: debounced arm level.
REQ-010 Port trigger, output, 1 bit: door_db OR motion_db, gated by arm.
REQ-011 Port confirm, output, 1 bit: entry delay expired while trigger is held.
REQ-012 Port trig_count, output, 8 bits: saturating count of trigger rising edges.
REQ-013 Port state, output, 2 bits: entry-delay FSM state, for debug.

Function
REQ-014 Each raw input SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-015 Each channel SHALL have its own debounce counter, 8 bits wide.
REQ-016 The debounce counter SHALL clear on any cycle where the synchronized value equals the debounced value.
REQ-017 The debounce counter SHALL increment on any cycle where the synchronized value differs from the debounced value.
REQ-018 When the counter equals DEBOUNCE_CYCLES-1 and a mismatch is still present, the debounced value SHALL flip and the counter SHALL clear on that edge.
REQ-019 A clean raw level change SHALL appear on the debounced value on the (DEBOUNCE_CYCLES+2)th rising clk edge after the change; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT appear.
REQ-020 arm SHALL equal the arm debounced register; trigger SHALL equal arm AND (door_db OR motion_db), both registered values.
REQ-021 The FSM SHALL have states IDLE=2'b00, COUNT=2'b01 and CONFIRMED=2'b10; encoding 2'b11 SHALL return to IDLE on the next edge.
REQ-022 IDLE: when trigger=1, the FSM SHALL move to COUNT and load timer=0.
REQ-023 COUNT: when trigger=0, the FSM SHALL return to IDLE.
REQ-024 COUNT: when timer=DELAY_CYCLES-1 and trigger=1, the FSM SHALL move to CONFIRMED; otherwise timer SHALL increment.
REQ-025 CONFIRMED: when trigger=0, the FSM SHALL return to IDLE.
REQ-026 confirm SHALL be 1 only in CONFIRMED; if trigger rises at edge t and is held, confirm SHALL rise at edge t+DELAY_CYCLES+1.
REQ-027 Disarm (arm=0) SHALL force trigger=0, which returns the FSM to IDLE on the next edge from any state.
REQ-028 trig_count SHALL increment by 1 on each trigger 0->1 transition and SHALL saturate at 255.
REQ-029 When clr_count=1, trig_count SHALL become 0; when clr_count and a trigger rise occur in the same cycle, the clear SHALL win and the result SHALL be 0.

Reset
REQ-030 While rst=1, all synchronizer flops, debounce values, debounce counters, timer and trig_count SHALL be 0, the FSM SHALL be IDLE, and arm, trigger and confirm SHALL be 0.
REQ-031 Reset asserted mid-COUNT or in CONFIRMED SHALL drop confirm immediately, without waiting for a clock edge.
REQ-032 After rst deasserts, a raw input already high SHALL obey the latency in REQ-019.

Verification
REQ-033 arm_raw 0->1 and held, with DEBOUNCE_CYCLES=4 -> arm rises on the 6th edge after the change; a 3-cycle arm_raw pulse -> arm stays 0.
REQ-034 Armed, door_raw held high, DELAY_CYCLES=8 -> state 01, then 10; confirm rises 9 edges after trigger rises; trig_count=1.
REQ-035 Armed, motion_raw dropped while in COUNT with timer=5 -> state 00 and confirm never asserts.
REQ-036 In CONFIRMED, arm_raw released -> arm falls after 6 edges, then trigger=0, state=00 and confirm=0 one edge later.
REQ-037 300 trigger rising edges -> trig_count=255; clr_count pulsed in the same cycle as a trigger rise -> trig_count=0.
REQ-038 rst pulsed asynchronously while in CONFIRMED -> confirm, arm, trigger and trig_count read 0 before the next clk edge.

Source files
------------

// File: rtl/sensor_conditioner.sv
// Alarm front end: synchronizes and debounces three raw inputs, then runs an
// entry-delay FSM and a saturating count of trigger rising edges.
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DELAY_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm_raw,
    input  logic       door_raw,
    input  logic       motion_raw,
    input  logic       clr_count,
    output logic       arm,
    output logic       trigger,
    output logic       confirm,
    output logic [7:0] trig_count,
    output logic [1:0] state
);

    localparam logic [7:0] DbLast    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] DelayLast = 8'(DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StCount     = 2'b01,
        StConfirmed = 2'b10,
        StBad       = 2'b11
    } state_t;

    // Channel index: 0 = arm, 1 = door, 2 = motion.
    logic [2:0] raw_vec;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] db_q;
    logic [7:0] db_cnt_q [3];

    assign raw_vec = {motion_raw, door_raw, arm_raw};

    for (genvar i = 0; i < 3; i++) begin : g_chan
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q[i]  <= 1'b0;
                sync2_q[i]  <= 1'b0;
                db_q[i]     <= 1'b0;
                db_cnt_q[i] <= 8'd0;
            end else begin
                sync1_q[i] <= raw_vec[i];
                sync2_q[i] <= sync1_q[i];
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= 8'd0;
                end else if (db_cnt_q[i] == DbLast) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= 8'd0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign arm     = db_q[0];
    assign trigger = db_q[0] & (db_q[1] | db_q[2]);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StCount;
                    timer_d = 8'd0;
                end
            end
            StCount: begin
                if (!trigger) begin
                    state_d = StIdle;
                end else if (timer_q == DelayLast) begin
                    state_d = StConfirmed;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StConfirmed: begin
                if (!trigger) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign confirm = (state_q == StConfirmed);
    assign state   = state_q;

    logic       trig_prev_q;
    logic [7:0] count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_prev_q <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            trig_prev_q <= trigger;
            count_q     <= count_d;
        end
    end

    // Clear takes priority over a simultaneous rising edge.
    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = 8'd0;
        end else if (trigger && !trig_prev_q && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    assign trig_count = count_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: stimulus queues expected output
// snapshots tagged with a cycle number; a negedge monitor pops and compares.
module tb_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm_raw, door_raw, motion_raw, clr_count;
    logic       arm, trigger, confirm;
    logic [7:0] trig_count;
    logic [1:0] state;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .DELAY_CYCLES   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm_raw   (arm_raw),
        .door_raw  (door_raw),
        .motion_raw(motion_raw),
        .clr_count (clr_count),
        .arm       (arm),
        .trigger   (trigger),
        .confirm   (confirm),
        .trig_count(trig_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // en bits: 0 arm, 1 trigger, 2 confirm, 3 state, 4 trig_count
    typedef struct {
        int         due;
        string      name;
        logic [4:0] en;
        logic       e_arm;
        logic       e_trig;
        logic       e_conf;
        logic [1:0] e_st;
        logic [7:0] e_cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int due, input string name, input logic [4:0] en,
                             input logic a, input logic t, input logic c,
                             input logic [1:0] s, input logic [7:0] n);
        exp_t e;
        e.due = due; e.name = name; e.en = en;
        e.e_arm = a; e.e_trig = t; e.e_conf = c; e.e_st = s; e.e_cnt = n;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                checks++; errors++;
                $display("FAIL %s: missed check, due cycle %0d seen at %0d", e.name, e.due, cyc);
            end else begin
                if (e.en[0]) begin
                    checks++;
                    if (arm !== e.e_arm) begin
                        errors++;
                        $display("FAIL %s arm: got %b want %b (cyc %0d)", e.name, arm, e.e_arm, cyc);
                    end
                end
                if (e.en[1]) begin
                    checks++;
                    if (trigger !== e.e_trig) begin
                        errors++;
                        $display("FAIL %s trigger: got %b want %b (cyc %0d)", e.name, trigger,
                                 e.e_trig, cyc);
                    end
                end
                if (e.en[2]) begin
                    checks++;
                    if (confirm !== e.e_conf) begin
                        errors++;
                        $display("FAIL %s confirm: got %b want %b (cyc %0d)", e.name, confirm,
                                 e.e_conf, cyc);
                    end
                end
                if (e.en[3]) begin
                    checks++;
                    if (state !== e.e_st) begin
                        errors++;
                        $display("FAIL %s state: got %b want %b (cyc %0d)", e.name, state,
                                 e.e_st, cyc);
                    end
                end
                if (e.en[4]) begin
                    checks++;
                    if (trig_count !== e.e_cnt) begin
                        errors++;
                        $display("FAIL %s trig_count: got %0d want %0d (cyc %0d)", e.name,
                                 trig_count, e.e_cnt, cyc);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        rst = 1'b1; arm_raw = 1'b0; door_raw = 1'b0; motion_raw = 1'b0; clr_count = 1'b0;
        step(2);
        expect_at(cyc, "reset", 5'b11111, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        step(1);
        rst = 1'b0;
        step(2);

        // 3-cycle arm glitch must be filtered
        c = cyc;
        arm_raw = 1'b1;
        expect_at(c + 6, "glitch_a", 5'b00001, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        expect_at(c + 9, "glitch_b", 5'b00001, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        step(3);
        arm_raw = 1'b0;
        step(10);

        // Clean arm: rises on 6th edge
        c = cyc;
        arm_raw = 1'b1;
        expect_at(c + 5, "arm_pre", 5'b00001, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        expect_at(c + 6, "arm_rise", 5'b00011, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        step(8);

        // Door held: trigger at c+6, COUNT at c+7, confirm at c+15
        c = cyc;
        door_raw = 1'b1;
        expect_at(c + 6, "door_trig", 5'b11010, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0);
        expect_at(c + 7, "door_count", 5'b11100, 1'b0, 1'b0, 1'b0, 2'b01, 8'd1);
        expect_at(c + 14, "door_pre_conf", 5'b01100, 1'b0, 1'b0, 1'b0, 2'b01, 8'd0);
        expect_at(c + 15, "door_conf", 5'b11100, 1'b0, 1'b0, 1'b1, 2'b10, 8'd1);
        step(20);

        // Disarm in CONFIRMED
        c = cyc;
        arm_raw = 1'b0;
        expect_at(c + 5, "disarm_pre", 5'b01111, 1'b1, 1'b1, 1'b1, 2'b10, 8'd0);
        expect_at(c + 6, "disarm_arm", 5'b01111, 1'b0, 1'b0, 1'b1, 2'b10, 8'd0);
        expect_at(c + 7, "disarm_idle", 5'b01100, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        step(10);
        door_raw = 1'b0;
        step(8);
        arm_raw = 1'b1;
        step(8);

        // Motion dropped so trigger falls while timer=5
        c = cyc;
        motion_raw = 1'b1;
        expect_at(c + 7, "motion_count", 5'b11000, 1'b0, 1'b0, 1'b0, 2'b01, 8'd2);
        expect_at(c + 12, "motion_fall", 5'b01010, 1'b0, 1'b0, 1'b0, 2'b01, 8'd0);
        expect_at(c + 13, "motion_idle", 5'b01100, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        expect_at(c + 16, "motion_noconf_a", 5'b01100, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        expect_at(c + 20, "motion_noconf_b", 5'b01100, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        step(6);
        motion_raw = 1'b0;
        step(18);

        // 300 rising edges, count saturates
        for (int i = 1; i <= 300; i++) begin
            motion_raw = 1'b1;
            step(7);
            if (i == 100 || i == 253 || i == 300)
                expect_at(cyc, "sat_count", 5'b10000, 1'b0, 1'b0, 1'b0, 2'b00,
                          8'((i + 2 > 255) ? 255 : i + 2));
            motion_raw = 1'b0;
            step(7);
        end

        // Clear in the same cycle as a trigger rise
        c = cyc;
        motion_raw = 1'b1;
        step(6);
        clr_count = 1'b1;
        step(1);
        clr_count = 1'b0;
        expect_at(c + 7, "clr_win", 5'b10000, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        expect_at(c + 9, "clr_hold", 5'b10010, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0);
        step(4);
        motion_raw = 1'b0;
        step(10);

        // Async reset in CONFIRMED
        c = cyc;
        motion_raw = 1'b1;
        expect_at(c + 15, "pre_rst", 5'b11111, 1'b1, 1'b1, 1'b1, 2'b10, 8'd1);
        step(16);
        rst = 1'b1;
        expect_at(cyc, "async_rst", 5'b11111, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        step(2);
        arm_raw = 1'b1;
        rst = 1'b0;
        c = cyc;
        expect_at(c + 5, "post_rst_pre", 5'b00001, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        expect_at(c + 6, "post_rst_arm", 5'b00011, 1'b1, 1'b1, 1'b0, 2'b00, 8'd0);

        for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d checks left unserviced, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
